// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into single-cycle short, double and long press
// events plus auto-repeat ticks while the button stays held after a long press.
module button_event_decoder #(
  parameter logic PRESSED_LEVEL = 1'b1,
  parameter int   LONG_CYCLES   = 12000000,
  parameter int   REPEAT_CYCLES = 3000000,
  parameter int   DOUBLE_CYCLES = 6000000,
  parameter bit   ENABLE_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic       repeat_tick,
  output logic       held,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ARMING         = 3'd0,
    IDLE           = 3'd1,
    PRESSED        = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4,
    LONG_HELD      = 3'd5
  } state_t;

  localparam int MAX_LR = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int MAX_C  = (MAX_LR > DOUBLE_CYCLES) ? MAX_LR : DOUBLE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LONG_C   = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] DOUBLE_C = CW'(DOUBLE_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] SAT_C    = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          short_d, double_d, long_d, repeat_d, held_d;
  logic          p;

  assign p         = (btn == PRESSED_LEVEL);
  assign cnt_inc   = (cnt_q == SAT_C) ? cnt_q : cnt_q + ONE_C;
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      ARMING: begin
        // Button held through reset must be released before anything counts.
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = ONE_C;
        end
      end
      PRESSED: begin
        if (p) begin
          if (cnt_inc >= LONG_C) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (DOUBLE_CYCLES == 0) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = WAIT_SECOND;
          cnt_d   = ONE_C;
        end
      end
      WAIT_SECOND: begin
        if (p) begin
          state_d = SECOND_PRESSED;
          cnt_d   = ONE_C;
        end else if (cnt_inc >= DOUBLE_C) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SECOND_PRESSED: begin
        if (!p) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_inc >= LONG_C) begin
          // First press is reported late; the second one became a long press.
          short_d = 1'b1;
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= REPEAT_C) begin
          repeat_d = ENABLE_REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ARMING;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == PRESSED) || (state_d == SECOND_PRESSED) || (state_d == LONG_HELD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARMING;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      held         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      double_press <= double_d;
      long_press   <= long_d;
      repeat_tick  <= repeat_d;
      held         <= held_d;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: two instances, one with doubles and repeat
// enabled, one with doubles and repeat disabled. Output vectors are {held,rep,long,dbl,short}.
module tb_button_event_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       short_a, double_a, long_a, repeat_a, held_a;
  logic       short_b, double_b, long_b, repeat_b, held_b;
  logic [2:0] st_a, st_b;

  localparam logic [4:0] H = 5'b10000;
  localparam logic [4:0] R = 5'b01000;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] D = 5'b00010;
  localparam logic [4:0] S = 5'b00001;
  localparam logic [4:0] Z = 5'b00000;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  button_event_decoder #(
    .PRESSED_LEVEL(1'b1), .LONG_CYCLES(8), .REPEAT_CYCLES(4),
    .DOUBLE_CYCLES(5), .ENABLE_REPEAT(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .btn(btn_a),
    .short_press(short_a), .double_press(double_a), .long_press(long_a),
    .repeat_tick(repeat_a), .held(held_a), .dbg_state(st_a)
  );

  button_event_decoder #(
    .PRESSED_LEVEL(1'b1), .LONG_CYCLES(8), .REPEAT_CYCLES(4),
    .DOUBLE_CYCLES(0), .ENABLE_REPEAT(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .btn(btn_b),
    .short_press(short_b), .double_press(double_b), .long_press(long_b),
    .repeat_tick(repeat_b), .held(held_b), .dbg_state(st_b)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one sample on instance A, let one edge pass, compare all outputs.
  task automatic tick_a(input logic b, input logic [4:0] exp, input string tag);
    btn_a = b;
    @(posedge clk);
    #1;
    check_eq(tag, {3'b000, held_a, repeat_a, long_a, double_a, short_a}, {3'b000, exp});
  endtask

  task automatic tick_b(input logic b, input logic [4:0] exp, input string tag);
    btn_b = b;
    @(posedge clk);
    #1;
    check_eq(tag, {3'b000, held_b, repeat_b, long_b, double_b, short_b}, {3'b000, exp});
  endtask

  initial begin
    logic       b;
    logic [4:0] e;

    // Reset and arming
    rst_n = 1'b0;
    for (int i = 1; i <= 2; i++) tick_a(1'b0, Z, $sformatf("rst_a_e%0d", i));
    check_eq("rst_b", {3'b000, held_b, repeat_b, long_b, double_b, short_b}, 8'h00);
    check_eq("rst_state_a", {5'b0, st_a}, 8'd0);
    rst_n = 1'b1;
    tick_a(1'b0, Z, "arm_a");
    check_eq("idle_state_a", {5'b0, st_a}, 8'd1);

    // 1: single short press, reported after the 5th released edge
    for (int i = 1; i <= 13; i++) begin
      b = (i <= 3);
      e = b ? H : ((i == 8) ? S : Z);
      tick_a(b, e, $sformatf("t1_e%0d", i));
    end

    // 2: double press
    for (int i = 1; i <= 15; i++) begin
      b = (i <= 3) || (i >= 6 && i <= 8);
      e = b ? H : ((i == 9) ? D : Z);
      tick_a(b, e, $sformatf("t2_e%0d", i));
    end

    // 3: long press then repeat ticks, release gives nothing
    for (int i = 1; i <= 23; i++) begin
      b = (i <= 20);
      e = b ? H : Z;
      if (i == 8) e = e | L;
      if (i >= 12 && i <= 20 && (i % 4) == 0) e = e | R;
      tick_a(b, e, $sformatf("t3_e%0d", i));
    end

    // 4: second press turns long: short+long together, then repeats
    for (int i = 1; i <= 24; i++) begin
      b = (i <= 3) || (i >= 6 && i <= 21);
      e = b ? H : Z;
      if (i == 13) e = e | S | L;
      if (i == 17 || i == 21) e = e | R;
      tick_a(b, e, $sformatf("t4_e%0d", i));
    end

    // 5: reset while in LONG_HELD with button still down
    for (int i = 1; i <= 10; i++) begin
      e = (i == 8) ? (H | L) : H;
      tick_a(1'b1, e, $sformatf("t5_pre_e%0d", i));
    end
    rst_n = 1'b0;
    tick_a(1'b1, Z, "t5_rst");
    check_eq("t5_rst_state", {5'b0, st_a}, 8'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) tick_a(1'b1, Z, $sformatf("t5_arm_e%0d", i));
    tick_a(1'b0, Z, "t5_release");
    check_eq("t5_idle_state", {5'b0, st_a}, 8'd1);
    for (int i = 1; i <= 9; i++) begin
      b = (i <= 3);
      e = b ? H : ((i == 8) ? S : Z);
      tick_a(b, e, $sformatf("t5_post_e%0d", i));
    end

    // 6: doubles off, repeat off
    for (int i = 1; i <= 7; i++) begin
      b = (i <= 3);
      e = b ? H : ((i == 4) ? S : Z);
      tick_b(b, e, $sformatf("t6a_e%0d", i));
    end
    for (int i = 1; i <= 22; i++) begin
      b = (i <= 20);
      e = b ? H : Z;
      if (i == 8) e = e | L;
      tick_b(b, e, $sformatf("t6b_e%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
